lbdr_pkt: RTL and testbench
===========================

# lbdr_pkt

Packet-aware, parametrised Logic-Based Distributed Routing unit for one input port of a mesh NoC router. It supports any mesh up to 2^ADDR_W x 2^ADDR_W nodes. Routing and connectivity bits are loaded at reset. The block computes a minimal route from each HEADER flit and holds the selected output port until the packet's TAIL flit is consumed. It sits between the input FIFO and the switch allocator, and adds error reporting and an optional deroute path.

## Interface
Parameters:
- ADDR_W, 2, width of each X/Y coordinate; node address is 2*ADDR_W bits, Y in the upper half, X in the lower half

Ports:
- clk  in  1  router clock
- rst  in  1  synchronous, active-high reset; loads configuration
- Rxy_rst  in  8  routing bits, sampled during rst; bit order [Rne,Rnw,Ren,Res,Rwn,Rws,Rse,Rsw] = bits 0..7
- Cx_rst  in  4  connectivity bits, sampled during rst; bit order [Cn,Ce,Cw,Cs] = bits 0..3
- cur_addr_rst  in  2*ADDR_W  this router's address, sampled during rst
- dr_rst  in  2  deroute port, sampled during rst (N=0, E=1, W=2, S=3); ignored unless LBDR_DEROUTE_EN
- empty  in  1  input FIFO empty
- flit_id  in  3  type of the head-of-FIFO flit; HEADER, BODY or TAIL
- dst_addr  in  2*ADDR_W  destination address of the head flit; valid with HEADER only
- read_en  in  1  head flit consumed this cycle (crossbar grant)
- Nport, Eport, Wport, Sport, Lport  out  1 each  one-hot route request; all zero when no route is held
- busy  out  1  a packet route is held (FSM in ACTIVE)
- route_err  out  1  one-cycle pulse: the header has no usable port
- pkt_err  out  1  one-cycle pulse: protocol violation

## Operation
- Comparators on stored cur_addr vs dst_addr:
  - N1 = y_dst<y_cur
  - S1 = y_cur<y_dst
  - E1 = x_cur<x_dst
  - W1 = x_dst<x_cur
- Port equations:
  - Nport = ((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
  - Eport, Wport, Sport follow the same pattern with their own R bits and C bit.
  - Lport = ~N1&~E1&~W1&~S1.
- Multiple minimal ports asserted: priority N>E>W>S, so the output stays one-hot.
- FSM states:
  - IDLE: on !empty & flit_id==HEADER, register the route and go to ACTIVE. If no port is found, pulse route_err, keep outputs zero and stay in IDLE.
  - ACTIVE: outputs held; empty has no effect. On !empty & read_en & flit_id==TAIL, go to IDLE and clear outputs.
  - HEADER seen in ACTIVE (missing TAIL): pulse pkt_err, recompute the route from the new header, stay in ACTIVE.
  - BODY or TAIL seen in IDLE: pulse pkt_err, no state change.
- Packets are at least 2 flits; HEADER and TAIL are always distinct flits.

## Timing
- Reset values: all port outputs, busy, route_err and pkt_err are 0; FSM is IDLE.
- Defaults before the first reset: Rxy=8'h3C, Cx=4'hF, cur_addr=5.
- Route latency: outputs are valid in the cycle after the header is sampled; busy rises in the same cycle.
- Route release: outputs and busy fall in the cycle after the TAIL read_en.
- Simultaneous TAIL read_en and HEADER are not possible (single head flit per cycle).
- rst mid-packet: outputs clear and configuration reloads on the next edge; the in-flight packet is abandoned with no error pulse.

## Configuration
- LBDR_DEROUTE_EN defined:
  - Applies when the minimal route is empty and the destination is not local.
  - If the C bit of port dr is set, that port is asserted and the FSM enters ACTIVE; otherwise route_err pulses.
- LBDR_DEROUTE_EN undefined: dr_rst is unused; an empty minimal route always gives route_err.

## Structure
- Shared package lbdr_pkg holds:
  - flit_id constants: HEADER=3'b001, BODY=3'b010, TAIL=3'b100
  - port index enum: N, E, W, S
  - FSM state typedef
  - bit-index constants for Rxy and Cx
- One sub-module, lbdr_route_comb: purely combinational comparators, port equations and priority encoding, parametrised by ADDR_W. The top level holds the config registers and the FSM.

## Test plan
- ADDR_W=2, cur=5, Rxy=8'h3C, Cx=4'hF; HEADER dst=5, then TAIL with read_en -> Lport=1 one cycle after the header, cleared one cycle after the TAIL read_en.
- Same config; HEADER dst=0, then BODY flits with empty toggling, then TAIL -> Wport is held through all empty cycles (Rwn=1), busy stays 1, ports clear after the TAIL read_en.
- Cx=4'b1110 (north disconnected); HEADER dst=1 -> route_err pulse, all ports 0, busy=0. With LBDR_DEROUTE_EN and dr=E -> Eport=1 instead.
- HEADER dst=15, then a second HEADER dst=0 before any TAIL -> pkt_err pulse; route changes from Eport to Wport one cycle later.
- Assert rst in the middle of a packet with cur_addr_rst=10 -> outputs are 0 on the next cycle; a following HEADER dst=10 gives Lport=1.
- ADDR_W=3, cur=8'h00, HEADER dst=8'h77 -> Sport=1 (Rse=1 for the SE quadrant; Eport not asserted).

Source files
------------

// File: rtl/lbdr_pkg.sv
// Shared constants and types for the packet-aware LBDR routing unit:
// flit types, output-port indices, FSM states and configuration bit positions.
package lbdr_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_E = 2'd1,
    PORT_W = 2'd2,
    PORT_S = 2'd3
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Rxy bit positions
  localparam int R_NE = 0;
  localparam int R_NW = 1;
  localparam int R_EN = 2;
  localparam int R_ES = 3;
  localparam int R_WN = 4;
  localparam int R_WS = 5;
  localparam int R_SE = 6;
  localparam int R_SW = 7;

  // Cx bit positions (also the N/E/W/S bit positions of a route vector)
  localparam int C_N = 0;
  localparam int C_E = 1;
  localparam int C_W = 2;
  localparam int C_S = 3;

  // Route vector bit for the local port
  localparam int ROUTE_L = 4;

  localparam logic [7:0] RXY_DEFAULT      = 8'h3C;
  localparam logic [3:0] CX_DEFAULT       = 4'hF;
  localparam int         CUR_ADDR_DEFAULT = 5;

  function automatic logic [4:0] port_onehot(input port_e p);
    return 5'b00001 << p;
  endfunction

endpackage

// File: rtl/lbdr_route_comb.sv
// Combinational LBDR route computation: coordinate comparators, port equations
// and N>E>W>S priority. LBDR_DEROUTE_EN enables the fallback deroute port.
module lbdr_route_comb
  import lbdr_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic [2*ADDR_W-1:0] cur_addr_i,
  input  logic [2*ADDR_W-1:0] dst_addr_i,
  input  logic [7:0]          rxy_i,
  input  logic [3:0]          cx_i,
  input  logic [1:0]          dr_i,
  output logic [4:0]          route_o,
  output logic                no_route_o
);

  logic [ADDR_W-1:0] x_cur, y_cur, x_dst, y_dst;
  logic              n1, s1, e1, w1, local_hit;
  logic [3:0]        min_raw;

  assign x_cur = cur_addr_i[ADDR_W-1:0];
  assign y_cur = cur_addr_i[2*ADDR_W-1:ADDR_W];
  assign x_dst = dst_addr_i[ADDR_W-1:0];
  assign y_dst = dst_addr_i[2*ADDR_W-1:ADDR_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  assign min_raw[C_N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_i[R_NE]) | (n1 & w1 & rxy_i[R_NW])) & cx_i[C_N];
  assign min_raw[C_E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_i[R_EN]) | (e1 & s1 & rxy_i[R_ES])) & cx_i[C_E];
  assign min_raw[C_W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_i[R_WN]) | (w1 & s1 & rxy_i[R_WS])) & cx_i[C_W];
  assign min_raw[C_S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_i[R_SE]) | (s1 & w1 & rxy_i[R_SW])) & cx_i[C_S];

  assign local_hit = ~n1 & ~e1 & ~w1 & ~s1;

`ifndef LBDR_DEROUTE_EN
  logic unused_dr;
  assign unused_dr = ^dr_i;
`endif

  always_comb begin
    route_o    = '0;
    no_route_o = 1'b0;
    if (local_hit) begin
      route_o[ROUTE_L] = 1'b1;
    end else if (min_raw[C_N]) begin
      route_o = port_onehot(PORT_N);
    end else if (min_raw[C_E]) begin
      route_o = port_onehot(PORT_E);
    end else if (min_raw[C_W]) begin
      route_o = port_onehot(PORT_W);
    end else if (min_raw[C_S]) begin
      route_o = port_onehot(PORT_S);
    end else begin
`ifdef LBDR_DEROUTE_EN
      if (cx_i[dr_i]) begin
        route_o = port_onehot(port_e'(dr_i));
      end else begin
        no_route_o = 1'b1;
      end
`else
      no_route_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/lbdr_pkt.sv
// Packet-aware LBDR unit: configuration registers and the IDLE/ACTIVE route-hold
// FSM around lbdr_route_comb. Optional deroute path: LBDR_DEROUTE_EN.
module lbdr_pkt
  import lbdr_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          Rxy_rst,
  input  logic [3:0]          Cx_rst,
  input  logic [2*ADDR_W-1:0] cur_addr_rst,
  input  logic [1:0]          dr_rst,
  input  logic                empty,
  input  logic [2:0]          flit_id,
  input  logic [2*ADDR_W-1:0] dst_addr,
  input  logic                read_en,
  output logic                Nport,
  output logic                Eport,
  output logic                Wport,
  output logic                Sport,
  output logic                Lport,
  output logic                busy,
  output logic                route_err,
  output logic                pkt_err
);

  localparam int AW2 = 2 * ADDR_W;
  localparam logic [AW2-1:0] CUR_DEF = AW2'(CUR_ADDR_DEFAULT);

  // Config is stored XORed with its default, so an all-zero power-up state
  // decodes to the default configuration before the first reset.
  logic [7:0]     rxy_x_q;
  logic [3:0]     cx_x_q;
  logic [AW2-1:0] cur_x_q;
  logic [1:0]     dr_q;

  logic [7:0]     rxy;
  logic [3:0]     cx;
  logic [AW2-1:0] cur_addr;

  state_e     state_q, state_d;
  logic [4:0] ports_q, ports_d;
  logic       route_err_q, route_err_d;
  logic       pkt_err_q, pkt_err_d;

  logic [4:0] route;
  logic       no_route;

  assign rxy      = rxy_x_q ^ RXY_DEFAULT;
  assign cx       = cx_x_q ^ CX_DEFAULT;
  assign cur_addr = cur_x_q ^ CUR_DEF;

  lbdr_route_comb #(.ADDR_W(ADDR_W)) u_route (
    .cur_addr_i (cur_addr),
    .dst_addr_i (dst_addr),
    .rxy_i      (rxy),
    .cx_i       (cx),
    .dr_i       (dr_q),
    .route_o    (route),
    .no_route_o (no_route)
  );

  always_comb begin
    state_d     = state_q;
    ports_d     = ports_q;
    route_err_d = 1'b0;
    pkt_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (flit_id == FLIT_HEADER) begin
            if (no_route) begin
              route_err_d = 1'b1;
            end else begin
              ports_d = route;
              state_d = ST_ACTIVE;
            end
          end else if (flit_id == FLIT_BODY || flit_id == FLIT_TAIL) begin
            pkt_err_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!empty) begin
          if (flit_id == FLIT_HEADER) begin
            // Missing TAIL: the new header takes over the port.
            pkt_err_d = 1'b1;
            if (no_route) begin
              route_err_d = 1'b1;
              ports_d     = '0;
              state_d     = ST_IDLE;
            end else begin
              ports_d = route;
            end
          end else if (flit_id == FLIT_TAIL && read_en) begin
            ports_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        ports_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_x_q     <= Rxy_rst ^ RXY_DEFAULT;
      cx_x_q      <= Cx_rst ^ CX_DEFAULT;
      cur_x_q     <= cur_addr_rst ^ CUR_DEF;
      dr_q        <= dr_rst;
      state_q     <= ST_IDLE;
      ports_q     <= '0;
      route_err_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ports_q     <= ports_d;
      route_err_q <= route_err_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign Nport     = ports_q[C_N];
  assign Eport     = ports_q[C_E];
  assign Wport     = ports_q[C_W];
  assign Sport     = ports_q[C_S];
  assign Lport     = ports_q[ROUTE_L];
  assign busy      = (state_q == ST_ACTIVE);
  assign route_err = route_err_q;
  assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_lbdr_pkt.sv
// Scoreboard bench for lbdr_pkt: a 4x4 instance (ADDR_W=2) and an 8x8 instance (ADDR_W=3).
module tb_lbdr_pkt;
  import lbdr_pkg::*;

  // Expected output vector: {N,E,W,S,L,busy,route_err,pkt_err}
  localparam logic [7:0] X_IDLE   = 8'h00;
  localparam logic [7:0] X_L      = 8'h0C;
  localparam logic [7:0] X_W      = 8'h24;
  localparam logic [7:0] X_E      = 8'h44;
  localparam logic [7:0] X_S      = 8'h14;
  localparam logic [7:0] X_RERR   = 8'h02;
  localparam logic [7:0] X_PERR   = 8'h01;
  localparam logic [7:0] X_W_PERR = 8'h25;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (ADDR_W=2)
  logic       rst_a, empty_a, rd_a;
  logic [7:0] rxy_a;
  logic [3:0] cx_a, cur_a, dst_a;
  logic [1:0] dr_a;
  logic [2:0] flit_a;
  logic       na, ea, wa, sa, la, busy_a, rerr_a, perr_a;
  logic [7:0] obs_a;

  // DUT B (ADDR_W=3)
  logic       rst_b, empty_b, rd_b;
  logic [7:0] rxy_b;
  logic [3:0] cx_b;
  logic [5:0] cur_b, dst_b;
  logic [1:0] dr_b;
  logic [2:0] flit_b;
  logic       nb, eb, wb, sb, lb, busy_b, rerr_b, perr_b;
  logic [7:0] obs_b;

  lbdr_pkt #(.ADDR_W(2)) dut_a (
    .clk(clk), .rst(rst_a), .Rxy_rst(rxy_a), .Cx_rst(cx_a), .cur_addr_rst(cur_a),
    .dr_rst(dr_a), .empty(empty_a), .flit_id(flit_a), .dst_addr(dst_a), .read_en(rd_a),
    .Nport(na), .Eport(ea), .Wport(wa), .Sport(sa), .Lport(la),
    .busy(busy_a), .route_err(rerr_a), .pkt_err(perr_a)
  );

  lbdr_pkt #(.ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .Rxy_rst(rxy_b), .Cx_rst(cx_b), .cur_addr_rst(cur_b),
    .dr_rst(dr_b), .empty(empty_b), .flit_id(flit_b), .dst_addr(dst_b), .read_en(rd_b),
    .Nport(nb), .Eport(eb), .Wport(wb), .Sport(sb), .Lport(lb),
    .busy(busy_b), .route_err(rerr_b), .pkt_err(perr_b)
  );

  assign obs_a = {na, ea, wa, sa, la, busy_a, rerr_a, perr_a};
  assign obs_b = {nb, eb, wb, sb, lb, busy_b, rerr_b, perr_b};

  // Scoreboard: bit 8 selects the instance, bits 7:0 the expected outputs
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [8:0] mon_e;
  logic [7:0] mon_obs;
  string      mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e    = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_obs  = mon_e[8] ? obs_b : obs_a;
      checks++;
      if (mon_obs !== mon_e[7:0]) begin
        failures++;
        $display("FAIL %s (dut_%s): got NEWSL/busy/rerr/perr=%b expected=%b",
                 mon_name, mon_e[8] ? "b" : "a", mon_obs, mon_e[7:0]);
      end
    end
  end

  // Driver tasks: inputs applied just after a rising edge, expectation pushed
  // for the edge that samples them.
  task automatic step_a(input string nm, input logic e, input logic [2:0] f,
                        input logic [3:0] d, input logic r, input logic [7:0] x);
    empty_a = e; flit_a = f; dst_a = d; rd_a = r;
    @(posedge clk);
    exp_q.push_back({1'b0, x});
    name_q.push_back(nm);
    #1;
  endtask

  task automatic step_b(input string nm, input logic e, input logic [2:0] f,
                        input logic [5:0] d, input logic r, input logic [7:0] x);
    empty_b = e; flit_b = f; dst_b = d; rd_b = r;
    @(posedge clk);
    exp_q.push_back({1'b1, x});
    name_q.push_back(nm);
    #1;
  endtask

  task automatic reset_a(input logic [7:0] rxy, input logic [3:0] cx,
                         input logic [3:0] cur, input logic [1:0] dr);
    rst_a = 1'b1; rxy_a = rxy; cx_a = cx; cur_a = cur; dr_a = dr;
    step_a("reset_a_0", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
    step_a("reset_a_1", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
    rst_a = 1'b0;
  endtask

  task automatic reset_b(input logic [7:0] rxy, input logic [3:0] cx,
                         input logic [5:0] cur, input logic [1:0] dr);
    rst_b = 1'b1; rxy_b = rxy; cx_b = cx; cur_b = cur; dr_b = dr;
    step_b("reset_b", 1'b1, FLIT_BODY, 6'd0, 1'b0, X_IDLE);
    rst_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rxy_a = 8'h00; cx_a = 4'h0; cur_a = 4'd0; dr_a = 2'd0;
    empty_a = 1'b1; flit_a = 3'b000; dst_a = 4'd0; rd_a = 1'b0;
    rst_b = 1'b0; rxy_b = 8'h00; cx_b = 4'h0; cur_b = 6'd0; dr_b = 2'd0;
    empty_b = 1'b1; flit_b = 3'b000; dst_b = 6'd0; rd_b = 1'b0;

    // Power-up defaults (cur=5, Rxy=3C): dst 0 lies NW, Rwn=1 -> West
    step_a("preset_hdr_west", 1'b0, FLIT_HEADER, 4'd0, 1'b0, X_W);
    step_a("preset_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);

    reset_a(8'h3C, 4'hF, 4'd5, 2'd1);

    // Local delivery
    step_a("local_hdr", 1'b0, FLIT_HEADER, 4'd5, 1'b0, X_L);
    step_a("local_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);

    // West held through BODY flits and empty cycles
    step_a("west_hdr", 1'b0, FLIT_HEADER, 4'd0, 1'b0, X_W);
    step_a("west_body_rd", 1'b0, FLIT_BODY, 4'd0, 1'b1, X_W);
    step_a("west_empty", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_W);
    step_a("west_empty_tail_ignored", 1'b1, FLIT_TAIL, 4'd0, 1'b1, X_W);
    step_a("west_body_wait", 1'b0, FLIT_BODY, 4'd0, 1'b0, X_W);
    step_a("west_tail_wait", 1'b0, FLIT_TAIL, 4'd0, 1'b0, X_W);
    step_a("west_tail_read", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);

    // Protocol errors in IDLE
    step_a("idle_body_err", 1'b0, FLIT_BODY, 4'd0, 1'b1, X_PERR);
    step_a("idle_after_body", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
    step_a("idle_tail_err", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_PERR);
    step_a("idle_after_tail", 1'b1, FLIT_TAIL, 4'd0, 1'b0, X_IDLE);

    // Missing TAIL: dst 15 (SE, Res=1) -> East, then dst 0 -> West with pkt_err
    step_a("se_hdr_east", 1'b0, FLIT_HEADER, 4'd15, 1'b0, X_E);
    step_a("second_hdr_west", 1'b0, FLIT_HEADER, 4'd0, 1'b0, X_W_PERR);
    step_a("second_body", 1'b0, FLIT_BODY, 4'd0, 1'b1, X_W);
    step_a("second_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);

    // North disconnected: dst 1 needs North only
    reset_a(8'h3C, 4'b1110, 4'd5, 2'd1);
`ifdef LBDR_DEROUTE_EN
    step_a("deroute_east", 1'b0, FLIT_HEADER, 4'd1, 1'b0, X_E);
    step_a("deroute_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);
`else
    step_a("no_route_err", 1'b0, FLIT_HEADER, 4'd1, 1'b0, X_RERR);
    step_a("no_route_idle", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
`endif

    // Reset in the middle of a packet, reloading cur_addr=10
    step_a("midpkt_hdr_west", 1'b0, FLIT_HEADER, 4'd0, 1'b0, X_W);
    rst_a = 1'b1; cx_a = 4'hF; cur_a = 4'd10;
    step_a("midpkt_reset", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
    rst_a = 1'b0;
    step_a("after_reset_idle", 1'b1, FLIT_BODY, 4'd0, 1'b0, X_IDLE);
    step_a("new_cur_local", 1'b0, FLIT_HEADER, 4'd10, 1'b0, X_L);
    step_a("new_cur_local_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);
    step_a("new_cur_nw_west", 1'b0, FLIT_HEADER, 4'd5, 1'b0, X_W);
    step_a("new_cur_nw_tail", 1'b0, FLIT_TAIL, 4'd0, 1'b1, X_IDLE);

    // 8x8 mesh, cur=0, dst=(7,7): Rse=1/Res=0 -> South
    reset_b(8'hF4, 4'hF, 6'd0, 2'd0);
    step_b("b_se_south", 1'b0, FLIT_HEADER, 6'o77, 1'b0, X_S);
    step_b("b_se_tail", 1'b0, FLIT_TAIL, 6'd0, 1'b1, X_IDLE);
    // Both E and S minimal: priority picks East
    reset_b(8'hFF, 4'hF, 6'd0, 2'd0);
    step_b("b_prio_east", 1'b0, FLIT_HEADER, 6'o77, 1'b0, X_E);
    step_b("b_prio_tail", 1'b0, FLIT_TAIL, 6'd0, 1'b1, X_IDLE);
    // East disconnected: falls to South
    reset_b(8'hFF, 4'b1101, 6'd0, 2'd0);
    step_b("b_no_east_south", 1'b0, FLIT_HEADER, 6'o77, 1'b0, X_S);
    step_b("b_no_east_tail", 1'b0, FLIT_TAIL, 6'd0, 1'b1, X_IDLE);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
